// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit and the datapath.
// Carries the instruction fields and ALU Zero flag into the controller, and
// every datapath select/enable back out.
//   master : the control unit (reads instruction fields, drives selects)
//   slave  : the datapath side (drives instruction fields, reads selects)
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALU_control;
  logic       instr_done;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALU_control, instr_done
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALU_control, instr_done
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control unit of the multicycle RV32I-subset core.
// Moore FSM stepping each instruction through fetch/decode/execute/memory/
// writeback, plus the immediate-format decode and the ALU decoder.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; returns the FSM to FETCH and gates
//           all write enables low while asserted
//   bus   : multicycle_control_if.master (instruction fields + Zero in,
//           datapath selects/enables + instr_done out)
//
// state      | meaning
// -----------+-------------------------------------------------------
// FETCH      | read instruction at PC, PC <= PC + 4
// DECODE     | read registers, branch target into ALUOut
// MEMADR     | rs1 + imm for LW/SW
// MEMREAD    | read data memory at ALUOut
// MEMWB      | write loaded data to rd
// MEMWRITE   | write rs2 to data memory at ALUOut
// EXECUTER   | rs1 op rs2
// EXECUTEI   | rs1 op imm
// ALUWB      | write ALUOut to rd
// BEQ        | compare rs1/rs2, take branch on Zero
// JAL        | rd link value OldPC + 4, PC <= jump target
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_e;

  state_e state_q, state_d;

  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [1:0] imm_src;
  logic [2:0] alu_control;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            // illegal opcode retires here with nothing written
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // op[5] separates R-type (SUB allowed) from I-type (funct7b5 is imm bit)
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // write enables are held off while reset is asserted
  assign bus.PCWrite     = ~reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite     = ~reset & ir_write;
  assign bus.MemWrite    = ~reset & mem_write;
  assign bus.RegWrite    = ~reset & reg_write;
  assign bus.AdrSrc      = adr_src;
  assign bus.ResultSrc   = result_src;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ImmSrc      = imm_src;
  assign bus.ALU_control = alu_control;
  assign bus.instr_done  = instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a cycle-indexed reference model
// of each instruction class predicts every output in every cycle.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] dut_vec;
  assign dut_vec = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                    bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                    bus.ALU_control, bus.instr_done};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int latency(input logic [6:0] op);
    case (op)
      OP_LW:                     return 5;
      OP_SW, OP_R, OP_I, OP_JAL: return 4;
      OP_BEQ:                    return 3;
      default:                   return 2;
    endcase
  endfunction

  // Expected outputs in cycle k (1 = FETCH) of an instruction.
  function automatic logic [16:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic z, input int k,
                                        input logic rst);
    logic pcw, adr, memw, irw, regw, done;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu, arith;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; done = 0;
    res = 0; sa = 0; sb = 0; alu = 3'b000;
    imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    case (f3)
      3'b000:  arith = (op == OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  arith = 3'b101;
      3'b110:  arith = 3'b011;
      3'b111:  arith = 3'b010;
      default: arith = 3'b000;
    endcase
    if (k == 1) begin
      pcw = 1; irw = 1; sb = 2'b10; res = 2'b10;
    end else if (k == 2) begin
      sa = 2'b01; sb = 2'b01;
      done = (latency(op) == 2);
    end else begin
      case (op)
        OP_LW, OP_SW: begin
          if (k == 3) begin sa = 2'b10; sb = 2'b01; end
          else if (op == OP_SW) begin adr = 1; memw = 1; done = 1; end
          else if (k == 4) adr = 1;
          else begin res = 2'b01; regw = 1; done = 1; end
        end
        OP_R, OP_I: begin
          if (k == 3) begin sa = 2'b10; sb = (op == OP_I) ? 2'b01 : 2'b00; alu = arith; end
          else begin regw = 1; done = 1; end
        end
        OP_BEQ: begin sa = 2'b10; alu = 3'b001; pcw = z; done = 1; end
        OP_JAL: begin
          if (k == 3) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
          else begin regw = 1; done = 1; end
        end
        default: ;
      endcase
    end
    if (rst) begin pcw = 0; irw = 0; memw = 0; regw = 0; end
    return {pcw, adr, memw, irw, regw, res, sa, sb, imm, alu, done};
  endfunction

  // Entered #1 after the edge that starts FETCH. zmode: 0/1 force Zero, 2 random.
  // abort_at > 0 raises reset during that cycle and checks the recovery.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_at);
    logic z;
    int lat;
    lat = latency(op);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    for (int k = 1; k <= lat; k++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      bus.Zero = z;
      if (k == abort_at) reset = 1'b1;
      @(negedge clk);
      check_val($sformatf("%s_c%0d", name, k), 32'(dut_vec), 32'(model(op, f3, f7, z, k, reset)));
      @(posedge clk); #1;
      if (k == abort_at) break;
    end
    if (abort_at > 0) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        check_val($sformatf("%s_rst%0d", name, j), 32'(dut_vec),
                  32'(model(op, f3, f7, bus.Zero, 1, 1'b1)));
        @(posedge clk); #1;
      end
      reset = 1'b0;
    end
  endtask

  logic [6:0] legal_ops [6];
  logic [6:0] bad_ops [5];

  initial begin
    legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    bad_ops   = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1100111, 7'b0010111};
    reset = 1'b1;
    bus.op = OP_LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("reset_fetch", 32'(dut_vec), 32'(model(OP_LW, 3'b000, 1'b0, 1'b0, 1, 1'b1)));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr("lw",      OP_LW,  3'b010, 1'b0, 2, 0);
    run_instr("r_sub",   OP_R,   3'b000, 1'b1, 2, 0);
    run_instr("r_add",   OP_R,   3'b000, 1'b0, 2, 0);
    run_instr("r_slt",   OP_R,   3'b010, 1'b0, 2, 0);
    run_instr("r_or",    OP_R,   3'b110, 1'b0, 2, 0);
    run_instr("r_and",   OP_R,   3'b111, 1'b1, 2, 0);
    run_instr("addi",    OP_I,   3'b000, 1'b1, 2, 0);
    run_instr("beq_t",   OP_BEQ, 3'b000, 1'b0, 1, 0);
    run_instr("beq_nt",  OP_BEQ, 3'b000, 1'b0, 0, 0);
    run_instr("sw",      OP_SW,  3'b010, 1'b0, 1, 0);
    run_instr("jal",     OP_JAL, 3'b101, 1'b1, 1, 0);
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1, 0);
    run_instr("lw_abort", OP_LW, 3'b010, 1'b0, 2, 4);
    run_instr("r_after", OP_R,   3'b000, 1'b1, 2, 0);

    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 5) == 0) op = bad_ops[$urandom_range(0, 4)];
      else                           op = legal_ops[$urandom_range(0, 5)];
      run_instr($sformatf("rnd%0d_op%b", n, op), op, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
